// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit beside the E-stage ALU; owns the HI/LO registers.
// Results are computed at the start edge and committed to HI/LO when the busy window closes.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [63:0] mul_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ax, bx, p;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    p  = ax * bx;
    return p;
  endfunction

  function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Returns {remainder, quotient}; the INT_MIN / -1 overflow is pinned explicitly.
  function automatic logic [63:0] div_s(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    if (b == 32'd0) sb = 32'sd1;
    else            sb = b;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'sd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] db;
    db = (b == 32'd0) ? 32'd1 : b;
    return {a % db, a / db};
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic        wr_q, wr_d;
  logic        op_ok;

  assign op_ok = (md_op >= OP_MULT) && (md_op <= OP_DIVU);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    case (state_q)
      IDLE: begin
        if (start && op_ok) begin
          state_d = RUN;
          busy_d  = 1'b1;
          wr_d    = 1'b1;
          case (md_op)
            OP_MULT:  {res_hi_d, res_lo_d} = mul_s(src_a, src_b);
            OP_MULTU: {res_hi_d, res_lo_d} = mul_u(src_a, src_b);
            OP_DIV:   {res_hi_d, res_lo_d} = div_s(src_a, src_b);
            default:  {res_hi_d, res_lo_d} = div_u(src_a, src_b);
          endcase
          if (md_op == OP_MULT || md_op == OP_MULTU) begin
            cnt_d = 32'(MULT_CYCLES);
          end else begin
            cnt_d = 32'(DIV_CYCLES);
            // A zero divisor still occupies the unit but leaves HI/LO untouched.
            wr_d  = (src_b != 32'd0);
          end
        end else if (!start && md_op == OP_MTHI) begin
          hi_d = src_a;
        end else if (!start && md_op == OP_MTLO) begin
          lo_d = src_a;
        end
      end
      default: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 32'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    case (md_op)
      OP_MFHI: md_out = hi_q;
      OP_MFLO: md_out = lo_q;
      default: md_out = 32'd0;
    endcase
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: multiply/divide results, busy window length, mthi/mtlo,
// ignored starts and asynchronous reset abort.
module tb_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int vectors = 0;
  int errs    = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; leaves the bench 1 unit after the edge where busy fell.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n, input logic [31:0] eh,
                       input logic [31:0] el);
    int cyc;
    cyc   = 0;
    md_op = op;
    src_a = a;
    src_b = b;
    start = 1'b1;
    step();
    start = 1'b0;
    md_op = 4'd0;
    src_a = $urandom;
    src_b = $urandom;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      step();
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(n));
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    int cyc;
    reset = 1'b0;
    start = 1'b0;
    md_op = 4'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_md_out", md_out, 32'd0);
    reset = 1'b1;
    step();

    do_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    do_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // mthi / mtlo on consecutive cycles, no busy
    md_op = 4'd7;
    src_a = 32'h0000_ABCD;
    step();
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h0000_ABCD);
    md_op = 4'd8;
    src_a = 32'h0000_1234;
    step();
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_1234);
    md_op = 4'd5;
    #1;
    chk("mfhi", md_out, 32'h0000_ABCD);
    md_op = 4'd6;
    #1;
    chk("mflo", md_out, 32'h0000_1234);
    md_op = 4'd9;
    #1;
    chk("md_out_other", md_out, 32'd0);
    step();

    // divide by zero leaves HI/LO as written
    md_op = 4'd7;
    src_a = 32'h11;
    step();
    md_op = 4'd8;
    src_a = 32'h22;
    step();
    do_op("div0", 4'd3, 32'd55, 32'd0, 10, 32'h11, 32'h22);

    // second start and mthi during busy are ignored
    md_op = 4'd3;
    src_a = 32'd100;
    src_b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    md_op = 4'd0;
    cyc   = 0;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      if (cyc == 3) begin
        start = 1'b1;
        md_op = 4'd1;
        src_a = 32'd5;
        src_b = 32'd5;
      end else if (cyc == 4) begin
        start = 1'b0;
        md_op = 4'd7;
        src_a = 32'hDEAD_BEEF;
      end else if (cyc == 5) begin
        md_op = 4'd0;
      end
      step();
    end
    chk("ign_cycles", 32'(cyc), 32'd10);
    chk("ign_hi", hi, 32'd1);
    chk("ign_lo", lo, 32'd33);
    step();
    chk("ign_no_restart", {31'd0, busy}, 32'd0);

    // asynchronous reset during busy cycle 4
    md_op = 4'd3;
    src_a = 32'd100;
    src_b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    md_op = 4'd0;
    step();
    step();
    step();
    chk("arst_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    step();
    step();
    #2;
    reset = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("arst_post_busy", {31'd0, busy}, 32'd0);
    chk("arst_post_hi", hi, 32'd0);
    chk("arst_post_lo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
